// File: rtl/user_irq_tx.sv
// rtl/user_irq_tx.sv - NVMe I/O request transmitter: commands to 128-bit RQ TLPs with a read-tag pool
module user_irq_tx #(
  parameter int AXI4_RQ_TUSER_WIDTH = 60,
  parameter int C_DATA_WIDTH        = 128,
  parameter int KEEP_WIDTH          = C_DATA_WIDTH / 32,
  parameter int NUM_TAGS            = 32
) (
  input  logic                           user_clk,
  input  logic                           user_reset_n,
  input  logic                           user_lnk_up,
  input  logic                           cmd_valid,
  output logic                           cmd_ready,
  input  logic                           cmd_is_write,
  input  logic [63:0]                    cmd_addr,
  input  logic [10:0]                    cmd_dw_cnt,
  output logic [7:0]                     cmd_tag,
  input  logic [127:0]                   wr_data,
  input  logic                           wr_data_valid,
  output logic                           wr_data_ready,
  output logic [C_DATA_WIDTH-1:0]        s_axis_rq_tdata,
  output logic [KEEP_WIDTH-1:0]          s_axis_rq_tkeep,
  output logic                           s_axis_rq_tlast,
  output logic                           s_axis_rq_tvalid,
  output logic [AXI4_RQ_TUSER_WIDTH-1:0] s_axis_rq_tuser,
  input  logic                           s_axis_rq_tready,
  input  logic                           tag_free_valid,
  input  logic [7:0]                     tag_free_id,
  output logic [$clog2(NUM_TAGS):0]      tags_outstanding,
  output logic                           err_pulse
);

  localparam int TAG_BITS = $clog2(NUM_TAGS);
  localparam int CNT_W    = TAG_BITS + 1;

  typedef enum logic [1:0] {IDLE, DESC, DATA} state_t;
  state_t state, state_nxt;

  logic [NUM_TAGS-1:0]     tag_busy;
  logic                    tag_avail;
  logic [7:0]              free_tag;
  logic                    out_free, accept, start, alloc, desc_load;
  logic                    pay_take, pay_last, free_ok, free_bad;
  logic                    lat_write;
  logic [61:0]             lat_addr;
  logic [10:0]             lat_cnt, rem;
  logic [7:0]              lat_tag;
  logic                    d_write;
  logic [61:0]             d_addr;
  logic [10:0]             d_cnt;
  logic [7:0]              d_tag;
  logic [C_DATA_WIDTH-1:0] desc;
  logic [KEEP_WIDTH-1:0]   pay_keep;
  logic [3:0]              desc_last_be, pay_last_be;
  logic                    unused_addr_bits;

  assign unused_addr_bits = ^cmd_addr[1:0];

  // Lowest-numbered free tag; the downward scan leaves the smallest index last.
  always_comb begin
    tag_avail = 1'b0;
    free_tag  = 8'd0;
    for (int i = NUM_TAGS - 1; i >= 0; i--) begin
      if (!tag_busy[i]) begin
        tag_avail = 1'b1;
        free_tag  = 8'(i);
      end
    end
  end

  assign out_free  = !s_axis_rq_tvalid || s_axis_rq_tready;
  assign accept    = cmd_valid && cmd_ready;
  assign start     = accept && (cmd_dw_cnt != 11'd0);
  assign alloc     = start && !cmd_is_write;
  assign pay_take  = wr_data_valid && wr_data_ready;
  assign pay_last  = rem <= 11'd4;
  assign desc_load = ((state == IDLE) && start && out_free) || ((state == DESC) && out_free);

  always_ff @(posedge user_clk or negedge user_reset_n) begin
    if (!user_reset_n) state <= IDLE;
    else               state <= state_nxt;
  end

  // The descriptor bypasses DESC when the output stage can take it in the accept cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) begin
              if (!out_free)        state_nxt = DESC;
              else if (cmd_is_write) state_nxt = DATA;
            end
      DESC: if (out_free) state_nxt = lat_write ? DATA : IDLE;
      DATA: if (pay_take && pay_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready     = (state == IDLE) && user_lnk_up && (cmd_is_write || tag_avail);
    cmd_tag       = cmd_is_write ? 8'd0 : free_tag;
    wr_data_ready = (state == DATA) && out_free;
  end

  always_ff @(posedge user_clk or negedge user_reset_n) begin
    if (!user_reset_n) begin
      lat_write <= 1'b0;
      lat_addr  <= '0;
      lat_cnt   <= '0;
      lat_tag   <= '0;
      rem       <= '0;
    end else if (start) begin
      lat_write <= cmd_is_write;
      lat_addr  <= cmd_addr[63:2];
      lat_cnt   <= cmd_dw_cnt;
      lat_tag   <= cmd_tag;
      rem       <= cmd_dw_cnt;
    end else if (pay_take) begin
      rem <= rem - 11'd4;
    end
  end

  // In IDLE the descriptor is built straight from the command port.
  always_comb begin
    d_write = (state == IDLE) ? cmd_is_write   : lat_write;
    d_addr  = (state == IDLE) ? cmd_addr[63:2] : lat_addr;
    d_cnt   = (state == IDLE) ? cmd_dw_cnt     : lat_cnt;
    d_tag   = (state == IDLE) ? cmd_tag        : lat_tag;
    desc           = '0;
    desc[63:2]     = d_addr;
    desc[74:64]    = d_cnt;
    desc[78:75]    = {3'b000, d_write};
    desc[103:96]   = d_tag;
    desc_last_be   = (d_cnt > 11'd1) ? 4'hF : 4'h0;
    pay_last_be    = (lat_cnt > 11'd1) ? 4'hF : 4'h0;
    pay_keep       = '1;
    if (rem < 11'd4) pay_keep = KEEP_WIDTH'((32'd1 << rem[1:0]) - 32'd1);
  end

  always_ff @(posedge user_clk or negedge user_reset_n) begin
    if (!user_reset_n) begin
      s_axis_rq_tvalid <= 1'b0;
      s_axis_rq_tdata  <= '0;
      s_axis_rq_tkeep  <= '0;
      s_axis_rq_tlast  <= 1'b0;
      s_axis_rq_tuser  <= '0;
    end else if (desc_load) begin
      s_axis_rq_tvalid <= 1'b1;
      s_axis_rq_tdata  <= desc;
      s_axis_rq_tkeep  <= '1;
      s_axis_rq_tlast  <= !d_write;
      s_axis_rq_tuser  <= AXI4_RQ_TUSER_WIDTH'({desc_last_be, 4'hF});
    end else if (pay_take) begin
      s_axis_rq_tvalid <= 1'b1;
      s_axis_rq_tdata  <= wr_data;
      s_axis_rq_tkeep  <= pay_keep;
      s_axis_rq_tlast  <= pay_last;
      s_axis_rq_tuser  <= AXI4_RQ_TUSER_WIDTH'({pay_last_be, 4'hF});
    end else if (s_axis_rq_tready) begin
      s_axis_rq_tvalid <= 1'b0;
    end
  end

  // A free is judged against the pool before this cycle's allocation.
  assign free_ok  = tag_free_valid && ({1'b0, tag_free_id} < 9'(NUM_TAGS))
                    && tag_busy[tag_free_id[TAG_BITS-1:0]];
  assign free_bad = tag_free_valid && !free_ok;

  always_ff @(posedge user_clk or negedge user_reset_n) begin
    if (!user_reset_n) begin
      tag_busy         <= '0;
      tags_outstanding <= '0;
      err_pulse        <= 1'b0;
    end else begin
      if (alloc)   tag_busy[free_tag[TAG_BITS-1:0]]    <= 1'b1;
      if (free_ok) tag_busy[tag_free_id[TAG_BITS-1:0]] <= 1'b0;
      tags_outstanding <= tags_outstanding + CNT_W'(alloc) - CNT_W'(free_ok);
      err_pulse        <= (accept && (cmd_dw_cnt == 11'd0)) || free_bad;
    end
  end

endmodule

// File: tb/tb_user_irq_tx.sv
// tb/tb_user_irq_tx.sv - randomized bench for user_irq_tx against a beat-queue and tag-pool model
module tb_user_irq_tx;
  localparam int NT = 32;

  logic         user_clk = 1'b0;
  logic         user_reset_n = 1'b0;
  logic         user_lnk_up = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic         cmd_is_write = 1'b0;
  logic [63:0]  cmd_addr = '0;
  logic [10:0]  cmd_dw_cnt = '0;
  logic [7:0]   cmd_tag;
  logic [127:0] wr_data = '0;
  logic         wr_data_valid = 1'b0;
  logic         wr_data_ready;
  logic [127:0] s_axis_rq_tdata;
  logic [3:0]   s_axis_rq_tkeep;
  logic         s_axis_rq_tlast;
  logic         s_axis_rq_tvalid;
  logic [59:0]  s_axis_rq_tuser;
  logic         s_axis_rq_tready = 1'b0;
  logic         tag_free_valid = 1'b0;
  logic [7:0]   tag_free_id = '0;
  logic [5:0]   tags_outstanding;
  logic         err_pulse;

  user_irq_tx #(.AXI4_RQ_TUSER_WIDTH(60), .C_DATA_WIDTH(128), .KEEP_WIDTH(4), .NUM_TAGS(NT)) dut (
    .user_clk(user_clk), .user_reset_n(user_reset_n), .user_lnk_up(user_lnk_up),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_is_write(cmd_is_write),
    .cmd_addr(cmd_addr), .cmd_dw_cnt(cmd_dw_cnt), .cmd_tag(cmd_tag),
    .wr_data(wr_data), .wr_data_valid(wr_data_valid), .wr_data_ready(wr_data_ready),
    .s_axis_rq_tdata(s_axis_rq_tdata), .s_axis_rq_tkeep(s_axis_rq_tkeep),
    .s_axis_rq_tlast(s_axis_rq_tlast), .s_axis_rq_tvalid(s_axis_rq_tvalid),
    .s_axis_rq_tuser(s_axis_rq_tuser), .s_axis_rq_tready(s_axis_rq_tready),
    .tag_free_valid(tag_free_valid), .tag_free_id(tag_free_id),
    .tags_outstanding(tags_outstanding), .err_pulse(err_pulse)
  );

  always #5 user_clk = ~user_clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Background drivers: ready/payload always randomized, free/link either manual or random.
  int tready_pct = 100, wvalid_pct = 100;
  bit rand_free_en = 0, rand_link_en = 0;
  logic man_free_valid = 1'b0, man_lnk = 1'b0;
  logic [7:0] man_free_id = '0;

  always @(posedge user_clk) begin
    #2;
    s_axis_rq_tready = ($urandom_range(99) < tready_pct);
    wr_data_valid    = ($urandom_range(99) < wvalid_pct);
    wr_data          = {$urandom, $urandom, $urandom, $urandom};
    tag_free_valid   = rand_free_en ? ($urandom_range(7) == 0) : man_free_valid;
    tag_free_id      = rand_free_en ? 8'($urandom_range(35)) : man_free_id;
    user_lnk_up      = rand_link_en ? ($urandom_range(9) != 0) : man_lnk;
  end

  // Behavioural model: expected beat queue, tag pool as a bit array, remaining write dwords.
  typedef struct packed {
    logic [127:0] data;
    logic [3:0]   keep;
    logic         last;
    logic [7:0]   be;
  } beat_t;
  beat_t exp_q[$];
  bit    busy_m[NT];
  int    out_m = 0, wr_rem_m = 0;
  logic [3:0] wr_lbe_m = '0;
  bit    err_exp = 0;

  always @(negedge user_clk) begin
    bit next_err, free_legal, found;
    int lf, n;
    beat_t b;
    if (!user_reset_n) begin
      exp_q.delete();
      foreach (busy_m[t]) busy_m[t] = 0;
      out_m = 0; wr_rem_m = 0; err_exp = 0;
    end else begin
      chk("err_pulse", err_pulse, err_exp);
      chk("tags_outstanding", tags_outstanding, out_m);
      if (s_axis_rq_tvalid) begin
        if (exp_q.size() == 0) chk("rq_unexpected_beat", 1, 0);
        else begin
          chk("rq_data", s_axis_rq_tdata, exp_q[0].data);
          chk("rq_keep", s_axis_rq_tkeep, exp_q[0].keep);
          chk("rq_last", s_axis_rq_tlast, exp_q[0].last);
          chk("rq_user", s_axis_rq_tuser, {52'b0, exp_q[0].be});
          if (s_axis_rq_tready) void'(exp_q.pop_front());
        end
      end
      if (wr_rem_m == 0) chk("wr_ready_idle", wr_data_ready, 0);
      next_err = 0;
      free_legal = tag_free_valid && (tag_free_id < NT) && busy_m[tag_free_id[4:0]];
      if (cmd_valid && cmd_ready) begin
        chk("accept_link", user_lnk_up, 1);
        chk("accept_no_write_pending", wr_rem_m, 0);
        if (cmd_dw_cnt == 0) next_err = 1;
        else begin
          lf = 0; found = 0;
          for (int t = 0; t < NT; t++) if (!found && !busy_m[t]) begin lf = t; found = 1; end
          if (cmd_is_write) lf = 0;
          else begin
            chk("accept_tag_avail", found, 1);
            chk("cmd_tag", cmd_tag, lf);
            busy_m[lf] = 1; out_m++;
          end
          b.data = {24'b0, 8'(lf), 17'b0, 3'b000, cmd_is_write, cmd_dw_cnt, cmd_addr[63:2], 2'b00};
          b.keep = 4'hF;
          b.last = !cmd_is_write;
          b.be   = {(cmd_dw_cnt > 1) ? 4'hF : 4'h0, 4'hF};
          exp_q.push_back(b);
          if (cmd_is_write) begin
            wr_rem_m = cmd_dw_cnt;
            wr_lbe_m = (cmd_dw_cnt > 1) ? 4'hF : 4'h0;
          end
        end
      end
      if (wr_data_valid && wr_data_ready && wr_rem_m > 0) begin
        n = (wr_rem_m < 4) ? wr_rem_m : 4;
        b.data = wr_data;
        b.keep = '0;
        for (int k = 0; k < n; k++) b.keep[k] = 1'b1;
        b.last = (wr_rem_m <= 4);
        b.be   = {wr_lbe_m, 4'hF};
        exp_q.push_back(b);
        wr_rem_m -= n;
      end
      if (tag_free_valid) begin
        if (free_legal) begin busy_m[tag_free_id[4:0]] = 0; out_m--; end
        else next_err = 1;
      end
      err_exp = next_err;
    end
  end

  task automatic do_cmd(input bit wr, input logic [63:0] a, input logic [10:0] c, output logic [7:0] tag);
    bit ok = 0;
    @(posedge user_clk); #1;
    cmd_valid = 1; cmd_is_write = wr; cmd_addr = a; cmd_dw_cnt = c;
    tag = '0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge user_clk);
      if (cmd_ready) begin ok = 1; tag = cmd_tag; end
    end
    if (!ok) chk("cmd_accept_timeout", 0, 1);
    @(posedge user_clk); #1;
    cmd_valid = 0;
  endtask

  task automatic do_free(input logic [7:0] id);
    @(posedge user_clk); #1;
    man_free_valid = 1; man_free_id = id;
    @(posedge user_clk); #1;
    man_free_valid = 0;
  endtask

  // Watches one TLP from the cycle after acceptance; span is the cycle index of its tlast beat.
  task automatic capture(output int nb, output int span, output logic [127:0] d0,
                         output logic [59:0] u0, output logic [3:0] k1, output logic [3:0] kl);
    bit stalled = 0, done = 0;
    logic [127:0] hd = '0;
    nb = 0; span = 0; d0 = '0; u0 = '0; k1 = '0; kl = '0;
    for (int cyc = 1; cyc <= 300 && !done; cyc++) begin
      @(negedge user_clk);
      if (stalled) chk("stall_hold", s_axis_rq_tdata, hd);
      stalled = s_axis_rq_tvalid && !s_axis_rq_tready;
      hd = s_axis_rq_tdata;
      if (s_axis_rq_tvalid && s_axis_rq_tready) begin
        nb++;
        if (nb == 1) begin d0 = s_axis_rq_tdata; u0 = s_axis_rq_tuser; end
        if (nb == 2) k1 = s_axis_rq_tkeep;
        kl = s_axis_rq_tkeep;
        if (s_axis_rq_tlast) begin span = cyc; done = 1; end
      end
    end
    if (!done) chk("capture_timeout", 0, 1);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_cmd_ready"}, cmd_ready, 0);
    chk({nm, "_cmd_tag"}, cmd_tag, 0);
    chk({nm, "_wr_ready"}, wr_data_ready, 0);
    chk({nm, "_tvalid"}, s_axis_rq_tvalid, 0);
    chk({nm, "_tdata"}, s_axis_rq_tdata, 0);
    chk({nm, "_tkeep"}, s_axis_rq_tkeep, 0);
    chk({nm, "_tlast"}, s_axis_rq_tlast, 0);
    chk({nm, "_tuser"}, s_axis_rq_tuser, 0);
    chk({nm, "_outstanding"}, tags_outstanding, 0);
    chk({nm, "_err"}, err_pulse, 0);
  endtask

  initial begin
    logic [7:0] tg;
    int nb, span;
    logic [127:0] d0;
    logic [59:0] u0;
    logic [3:0] k1, kl;

    #1 chk_zero("reset");
    repeat (3) @(posedge user_clk);
    #1 user_reset_n = 1; man_lnk = 1;

    // Single read: one descriptor beat at N+1
    do_cmd(0, 64'h1234_5678_9ABC_DEF0, 11'd16, tg);
    chk("rd_tag", tg, 0);
    capture(nb, span, d0, u0, k1, kl);
    chk("rd_beats", nb, 1);
    chk("rd_span", span, 1);
    chk("rd_addr", d0[63:0], 64'h1234_5678_9ABC_DEF0);
    chk("rd_cnt", d0[74:64], 16);
    chk("rd_type", d0[78:75], 0);
    chk("rd_desc_tag", d0[103:96], 0);
    chk("rd_user", u0[7:0], 8'hFF);
    chk("rd_last", kl, 4'hF);
    do_free(8'd0);

    // Write of 6 dwords: descriptor + 2 payload beats, last keep 0x3
    do_cmd(1, 64'h0000_0000_0000_1000, 11'd6, tg);
    capture(nb, span, d0, u0, k1, kl);
    chk("wr6_beats", nb, 3);
    chk("wr6_span", span, 3);
    chk("wr6_type", d0[78:75], 4'b0001);
    chk("wr6_keep_first", k1, 4'hF);
    chk("wr6_keep_last", kl, 4'h3);

    // Write of 1 dword: last_be 0, payload keep 0x1
    do_cmd(1, 64'h0000_0000_0000_2004, 11'd1, tg);
    capture(nb, span, d0, u0, k1, kl);
    chk("wr1_beats", nb, 2);
    chk("wr1_span", span, 2);
    chk("wr1_user", u0[7:0], 8'h0F);
    chk("wr1_keep", k1, 4'h1);

    // Zero-length commands and illegal frees
    do_cmd(1, 64'h40, 11'd0, tg);
    @(negedge user_clk);
    chk("zero_wr_err", err_pulse, 1);
    chk("zero_wr_tvalid", s_axis_rq_tvalid, 0);
    do_cmd(0, 64'h80, 11'd0, tg);
    @(negedge user_clk);
    chk("zero_rd_err", err_pulse, 1);
    chk("zero_rd_outstanding", tags_outstanding, 0);
    do_free(8'd7);
    @(negedge user_clk);
    chk("free_unalloc_err", err_pulse, 1);
    chk("free_unalloc_outstanding", tags_outstanding, 0);
    do_free(8'd40);
    @(negedge user_clk);
    chk("free_range_err", err_pulse, 1);

    // Exhaust the pool, then free tag 5 under a pending read
    for (int i = 0; i < NT; i++) begin
      do_cmd(0, 64'(i) << 12, 11'd4, tg);
      chk("pool_tag", tg, i);
    end
    @(posedge user_clk); #1;
    cmd_valid = 1; cmd_is_write = 0; cmd_addr = 64'hF000; cmd_dw_cnt = 11'd4;
    repeat (3) begin
      @(negedge user_clk);
      chk("full_ready_low", cmd_ready, 0);
    end
    chk("full_outstanding", tags_outstanding, 32);
    @(posedge user_clk); #1;
    man_free_valid = 1; man_free_id = 8'd5;
    @(negedge user_clk);
    chk("free_cycle_ready_low", cmd_ready, 0);
    @(posedge user_clk); #1;
    man_free_valid = 0;
    @(negedge user_clk);
    chk("after_free_ready", cmd_ready, 1);
    chk("after_free_tag", cmd_tag, 5);
    @(posedge user_clk); #1;
    cmd_valid = 0;
    @(negedge user_clk);
    chk("refill_outstanding", tags_outstanding, 32);
    for (int i = 0; i < NT; i++) do_free(8'(i));

    // 8-beat write under 50% backpressure
    tready_pct = 50; wvalid_pct = 70;
    do_cmd(1, 64'hABCD_0000, 11'd32, tg);
    capture(nb, span, d0, u0, k1, kl);
    chk("wr32_beats", nb, 9);
    chk("wr32_keep_last", kl, 4'hF);

    // Random traffic with random frees and link drops
    tready_pct = 60;
    rand_free_en = 1; rand_link_en = 1;
    for (int i = 0; i < 40; i++) begin
      do_cmd(1'($urandom_range(1)), {$urandom, $urandom}, 11'($urandom_range(40)), tg);
      repeat ($urandom_range(3)) @(posedge user_clk);
    end
    rand_free_en = 0; rand_link_en = 0;
    tready_pct = 100; wvalid_pct = 100;
    repeat (100) @(posedge user_clk);
    @(negedge user_clk);
    chk("drain_empty", exp_q.size(), 0);

    // Reset in the middle of a long write
    do_cmd(0, 64'h100, 11'd8, tg);
    do_cmd(1, 64'h200, 11'd64, tg);
    repeat (2) @(posedge user_clk);
    @(posedge user_clk); #1;
    man_lnk = 0;
    #2 user_reset_n = 0;
    #1 chk_zero("midreset");
    repeat (2) @(posedge user_clk);
    #1 user_reset_n = 1; man_lnk = 1;
    do_cmd(0, 64'h300, 11'd2, tg);
    chk("post_reset_tag", tg, 0);
    capture(nb, span, d0, u0, k1, kl);
    chk("post_reset_beats", nb, 1);
    chk("post_reset_desc_tag", d0[103:96], 0);
    repeat (4) @(posedge user_clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
